// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with an internal baud divider.
// Bytes written on TX_Data/TX_Write queue in a small FIFO and are sent on RXD.
// Ports: Clock_100MHz, Reset_n (async, active-low), TX_Data[7:0], TX_Write,
//        TX_Full, TX_Busy, TX_Done (end-of-stop pulse), RXD (idle high).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic [7:0] TX_Data,
  input  logic       TX_Write,
  output logic       TX_Full,
  output logic       TX_Busy,
  output logic       TX_Done,
  output logic       RXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;
  state_t state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [BW-1:0] baud;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;

  logic rxd_d;
  logic done_d;
  logic push;
  logic pop;
  logic bit_end;

  // Full is judged on the pre-edge count, so a
  // write coinciding with a pop while full is lost.
  assign TX_Full = (count == DEPTH_C);
  assign TX_Busy = (state != IDLE)
                || (count != '0);
  assign push    = TX_Write && !TX_Full;
  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_d   = state;
    baud_d    = baud + 1'b1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    rxd_d     = RXD;
    done_d    = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        rxd_d  = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          rxd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = '0;
          rxd_d     = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            rxd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            rxd_d     = shift[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          done_d = 1'b1;
          // Chain the next frame with no idle gap.
          if (count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            rxd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      RXD     <= 1'b1;
      TX_Done <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      RXD     <= rxd_d;
      TX_Done <= done_d;
    end
  end

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge Clock_100MHz) begin
    if (push) begin
      mem[wr_ptr] <= TX_Data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Queue model predicts frames; a line monitor checks RXD/flags each cycle.
module tb_uart_tx_fifo;

  localparam int C  = 16;
  localparam int D  = 4;
  localparam int FL = 10 * C;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_write = 1'b0;
  logic       tx_full;
  logic       tx_busy;
  logic       tx_done;
  logic       rxd;

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH(D)
  ) dut (
    .Clock_100MHz(clk),
    .Reset_n(rst_n),
    .TX_Data(tx_data),
    .TX_Write(tx_write),
    .TX_Full(tx_full),
    .TX_Busy(tx_busy),
    .TX_Done(tx_done),
    .RXD(rxd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         st;
  } frame_t;

  // Reference model: pending bytes and scheduled frames.
  logic [7:0] pend[$];
  frame_t     sbq[$];
  int         cyc      = 0;
  int         next_pop = 0;
  int         last_end = 0;
  bit         exp_busy = 1'b0;
  bit         exp_full = 1'b0;
  int         m_sz;
  bit         m_acc;
  frame_t     m_f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      sbq.delete();
      next_pop = 0;
      last_end = 0;
      exp_busy = 1'b0;
      exp_full = 1'b0;
    end else begin
      cyc++;
      m_sz  = pend.size();
      m_acc = tx_write && (m_sz < D);
      if (m_sz > 0 && cyc >= next_pop) begin
        m_f.b  = pend.pop_front();
        m_f.st = cyc;
        sbq.push_back(m_f);
        next_pop = cyc + FL;
        last_end = cyc + FL;
      end
      if (m_acc) pend.push_back(tx_data);
      exp_busy = (pend.size() > 0) || (cyc < last_end);
      exp_full = (pend.size() == D);
    end
  end

  // Line monitor: pops frames as they become due.
  bit     act = 1'b0;
  frame_t cur;
  bit     exp_rxd;
  bit     exp_done;
  int     k;

  always @(negedge clk) begin
    if (!rst_n) begin
      act = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (act && cyc == cur.st + FL) begin
        act      = 1'b0;
        exp_done = 1'b1;
      end
      if (!act && sbq.size() > 0 && sbq[0].st == cyc) begin
        cur = sbq.pop_front();
        act = 1'b1;
      end
      exp_rxd = 1'b1;
      if (act) begin
        k = (cyc - cur.st) / C;
        if (k == 0) exp_rxd = 1'b0;
        else if (k <= 8) exp_rxd = cur.b[k-1];
      end
      chk("rxd", 32'(rxd), 32'(exp_rxd));
      chk("done", 32'(tx_done), 32'(exp_done));
      chk("busy", 32'(tx_busy), 32'(exp_busy));
      chk("full", 32'(tx_full), 32'(exp_full));
    end
  end

  task automatic wr_byte(input logic [7:0] b);
    @(negedge clk);
    tx_write = 1'b1;
    tx_data  = b;
  endtask

  task automatic wr_end();
    @(negedge clk);
    tx_write = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_write = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pend.size() > 0 || cyc < last_end + 2)
           && n < 20000) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      n++;
    end
    chk("idle_timeout", 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int n;
    int len;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rxd", 32'(rxd), 32'd1);
    chk("rst_full", 32'(tx_full), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;

    idle(1000);

    wr_byte(8'h41);
    wr_end();
    wait_idle();

    wr_byte(8'h55);
    wr_byte(8'hAA);
    wr_byte(8'h00);
    wr_byte(8'hFF);
    wr_end();
    wait_idle();

    wr_byte(8'hE7);
    wr_end();
    idle(5);
    for (int i = 1; i <= 6; i++) wr_byte(8'(i));
    wr_end();
    chk("ovf_full", 32'(tx_full), 32'd1);
    idle(3 * FL - 20);
    for (int i = 0; i < 4; i++) wr_byte(8'($urandom));
    wr_end();
    wait_idle();

    wr_byte(8'h10);
    wr_end();
    idle(3);
    for (int i = 0; i < 4; i++) wr_byte(8'(8'h11 + i));
    wr_end();
    n = 0;
    while (cyc != next_pop - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wp_align", 32'(n < 1000), 32'd1);
    chk("wp_full_before", 32'(tx_full), 32'd1);
    tx_write = 1'b1;
    tx_data  = 8'h99;
    @(negedge clk);
    tx_write = 1'b0;
    chk("wp_full_after", 32'(tx_full), 32'd0);
    chk("wp_busy_after", 32'(tx_busy), 32'd1);
    wait_idle();

    wr_byte(8'h3C);
    wr_end();
    repeat (1 + 4 * C + C / 2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rxd", 32'(rxd), 32'd1);
    chk("arst_busy", 32'(tx_busy), 32'd0);
    chk("arst_full", 32'(tx_full), 32'd0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    tx_write = 1'b1;
    tx_data  = 8'hC3;
    wr_end();
    wait_idle();

    for (int it = 0; it < 25; it++) begin
      idle($urandom_range(0, 300));
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        wr_byte(8'($urandom));
        if ($urandom_range(0, 3) == 0) wr_end();
      end
      wr_end();
    end
    wait_idle();

    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for the board's serial link to the host. It accepts bytes from on-chip logic through a write strobe into a small FIFO and serialises them onto `RXD`, the FPGA output wired to the host's receive pin. It runs directly on `Clock_100MHz` with an internal baud divider, so no separate slow clock is needed. It is the sending counterpart to the existing 8N1 receiver path and is intended to echo or report bytes back to the host.

## Interface
- `CLKS_PER_BIT`, 10416, clock cycles per serial bit (9600 baud at 100 MHz); legal range 2 to 65535.
- `FIFO_DEPTH`, 4, byte entries; must be a power of two, minimum 2.
- `Clock_100MHz`  input  1  system clock; all logic rising-edge.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `TX_Data`  input  8  byte to queue; sampled only when `TX_Write`=1.
- `TX_Write`  input  1  write strobe, one byte per high cycle.
- `TX_Full`  output  1  FIFO holds `FIFO_DEPTH` entries.
- `TX_Busy`  output  1  FIFO non-empty or frame in progress.
- `TX_Done`  output  1  one-cycle pulse at the end of each stop bit.
- `RXD`  output  1  serial line; idle high; registered.

## Operation
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. No parity. Each bit is held exactly `CLKS_PER_BIT` cycles.
- FIFO:
  - write pointer, read pointer, occupancy count of width clog2(`FIFO_DEPTH`+1).
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A write is accepted when `TX_Write`=1 and `TX_Full`=0, both sampled at the same edge. A write while full is dropped silently, with no state change.
- Simultaneous write and pop:
  - When not full: both happen, and the count is unchanged.
  - When full: the pop happens and the write is dropped, because `TX_Full` is sampled before the pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `RXD`=1. If count≠0: pop the head into shift register, `RXD`<=0, baud counter<=0, go to START.
  - START: at baud counter = `CLKS_PER_BIT`-1, drive bit 0 of the shift register, bit index<=0, go to DATA.
  - DATA: at the end of each bit period, if bit index=7 drive `RXD`<=1 and go to STOP; otherwise increment the index and drive the next bit.
  - STOP: at the end of the bit period, pulse `TX_Done`.
    - If count≠0: pop, `RXD`<=0, go to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- The baud counter resets to 0 at every bit boundary and saturates nowhere. Its width is clog2(`CLKS_PER_BIT`).
- `TX_Data` changes after acceptance do not affect queued bytes.
- `TX_Busy` = (state≠IDLE) or (count≠0), registered-equivalent.
- `TX_Full` = (count = `FIFO_DEPTH`).

## Timing
- Reset values (asynchronous, immediate on `Reset_n`=0): `RXD`=1, `TX_Full`=0, `TX_Busy`=0, `TX_Done`=0.
  - Also reset: FSM in IDLE, all counters and pointers at 0, FIFO empty.
  - A frame in flight is abandoned with no stop bit; `RXD` returns high immediately.
- Write latency, idle and empty case: `TX_Write` is sampled at edge E and count becomes 1 at E. At edge E+1 the FSM pops and `RXD` goes 0. `TX_Busy` is high from E.
- Frame length: 10×`CLKS_PER_BIT` cycles from the `RXD` fall to the `TX_Done` pulse edge inclusive. `TX_Done` is high for exactly the cycle after the final stop-bit cycle.
- `TX_Full` rises at the edge accepting the `FIFO_DEPTH`th pending byte. It falls at the edge of the next pop.
- Release of `Reset_n`: the first accepted write is at the first rising edge with `Reset_n`=1.

## Test plan
- Single byte, `CLKS_PER_BIT`=16: write 0x41 on an idle line.
  - `RXD` shows 0,1,0,0,0,0,0,1,0,1, each held 16 cycles.
  - The start bit begins one edge after the write.
  - `TX_Done` pulses once 160 cycles after the fall.
  - `TX_Busy` drops in the same cycle.
- Back-to-back: write 0x55, 0xAA, 0x00, 0xFF in 4 consecutive cycles.
  - Four contiguous frames with no idle cycle between stop and start.
  - Data bits LSB first match each byte.
  - 4 `TX_Done` pulses 160 cycles apart.
- Overflow, `FIFO_DEPTH`=4: while the first frame is in flight, write 6 bytes 0x01–0x06 continuously.
  - `TX_Full` asserts after 4 are pending, and the extra bytes are dropped.
  - The transmitted sequence contains only accepted bytes, in order.
  - The pointer wrap is exercised by a subsequent 4-byte burst.
- Simultaneous write+pop while full: assert `TX_Write` with 0x99 at the STOP→START pop edge with count=4.
  - 0x99 is never transmitted.
  - Count becomes 3.
- Reset mid-frame: assert `Reset_n`=0 during data bit 3 of 0x3C.
  - `RXD`=1, `TX_Busy`=0 and `TX_Full`=0 immediately, asynchronously.
  - After release, writing 0xC3 yields one clean frame.
- Idle stability: 1000 cycles after reset with no writes.
  - `RXD` is constantly 1.
  - `TX_Done` never pulses.
